// File: rtl/ahb_lite_master.sv
// AHB-Lite master: converts a valid/ready request stream into pipelined
// single NONSEQ transfers and reports one completion per transfer.
// The address stage (A) drives HADDR/HWRITE/HTRANS from registers; the data
// stage (D) tracks the transfer whose data phase is on the bus. A low HREADY
// freezes both stages.
module ahb_lite_master #(
    parameter int ADDR_W = 21,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    // request stream
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    // completion stream
    output logic              rsp_valid,
    output logic              rsp_write,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy,
    // AHB-Lite master interface
    output logic [ADDR_W-1:0] HADDR,
    output logic              HWRITE,
    output logic [1:0]        HTRANS,
    output logic [DATA_W-1:0] HWDATA,
    input  logic [DATA_W-1:0] HRDATA,
    input  logic              HREADY
);

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_NONSEQ = 2'b10
    } htrans_e;

    // A stage: address phase on the bus
    logic              a_vld_q,   a_vld_d;
    logic [ADDR_W-1:0] haddr_q,   haddr_d;
    logic              hwrite_q,  hwrite_d;
    logic [DATA_W-1:0] a_wdata_q, a_wdata_d;
    // D stage: data phase on the bus
    logic              d_vld_q,   d_vld_d;
    logic              d_wr_q,    d_wr_d;
    logic [DATA_W-1:0] hwdata_q,  hwdata_d;
    // completion outputs
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_write_q, rsp_write_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

    // Pipeline advance on HREADY; everything except rsp_valid holds in a wait.
    always_comb begin
        // NOTE: every _d starts at its held value so no path leaves a signal
        // unassigned, which would otherwise infer a latch.
        a_vld_d     = a_vld_q;
        haddr_d     = haddr_q;
        hwrite_d    = hwrite_q;
        a_wdata_d   = a_wdata_q;
        d_vld_d     = d_vld_q;
        d_wr_d      = d_wr_q;
        hwdata_d    = hwdata_q;
        rsp_valid_d = 1'b0;
        rsp_write_d = rsp_write_q;
        rsp_rdata_d = rsp_rdata_q;

        if (HREADY) begin
            // the transfer in data phase completes at this edge
            if (d_vld_q) begin
                rsp_valid_d = 1'b1;
                rsp_write_d = d_wr_q;
                if (!d_wr_q) begin
                    rsp_rdata_d = HRDATA;
                end
            end

            // address phase moves into data phase; only writes update HWDATA
            d_vld_d = a_vld_q;
            d_wr_d  = hwrite_q;
            if (a_vld_q && hwrite_q) begin
                hwdata_d = a_wdata_q;
            end

            // new address phase; HADDR/HWRITE keep their last value when idle
            if (req_valid) begin
                a_vld_d   = 1'b1;
                haddr_d   = req_addr;
                hwrite_d  = req_write;
                a_wdata_d = req_wdata;
            end else begin
                a_vld_d   = 1'b0;
            end
        end
    end

    // State registers with asynchronous reset dropping any in-flight transfer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_vld_q     <= 1'b0;
            haddr_q     <= '0;
            hwrite_q    <= 1'b0;
            a_wdata_q   <= '0;
            d_vld_q     <= 1'b0;
            d_wr_q      <= 1'b0;
            hwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            a_vld_q     <= a_vld_d;
            haddr_q     <= haddr_d;
            hwrite_q    <= hwrite_d;
            a_wdata_q   <= a_wdata_d;
            d_vld_q     <= d_vld_d;
            d_wr_q      <= d_wr_d;
            hwdata_q    <= hwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // HTRANS follows the registered A-stage valid, so it cannot change in a wait.
    htrans_e htrans;
    assign htrans = a_vld_q ? HTRANS_NONSEQ : HTRANS_IDLE;

    assign req_ready = HREADY;
    assign HADDR     = haddr_q;
    assign HWRITE    = hwrite_q;
    assign HTRANS    = htrans;
    assign HWDATA    = hwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_write = rsp_write_q;
    assign rsp_rdata = rsp_rdata_q;
    assign busy      = a_vld_q | d_vld_q;

endmodule
